// File: rtl/mux_n_reg_pkg.sv
// Shared types and helpers for the registered N:1 handshake mux.
package mux_n_reg_pkg;

  typedef enum logic {
    MODE_SEL = 1'b0,
    MODE_RR  = 1'b1
  } mode_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/mux_n_reg_if.sv
// Producer/consumer bundle around the registered N:1 mux.
interface mux_n_reg_if #(
  parameter int WIDTH = 32,
  parameter int N     = 8,
  parameter int SEL_W = 3
) ();

  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_valid;
  logic [N-1:0]       in_ready;
  logic               mode;
  logic [SEL_W-1:0]   sel;
  logic [WIDTH-1:0]   out_data;
  logic [SEL_W-1:0]   out_ch;
  logic               out_valid;
  logic               out_ready;

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    input  mode,
    input  sel,
    output out_data,
    output out_ch,
    output out_valid,
    input  out_ready
  );

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    output mode,
    output sel,
    input  out_data,
    input  out_ch,
    input  out_valid,
    output out_ready
  );

endinterface

// File: rtl/mux_n_reg_rr_arbiter.sv
// Round-robin priority pick: rotate by ptr, take lowest, rotate back.
module rr_arbiter #(
  parameter int N     = 8,
  parameter int SEL_W = 3
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [SEL_W-1:0] gnt_idx,
  output logic             any
);

  int         base;
  int         off;
  int         idx;
  logic [N-1:0] rot;
  logic [N-1:0] rgnt;

  always_comb begin
    base = (int'(ptr) < N) ? int'(ptr) : 0;
    rot  = N'({req, req} >> base);
    rgnt = '0;
    off  = 0;
    any  = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (rot[i] && !any) begin
        rgnt[i] = 1'b1;
        off     = i;
        any     = 1'b1;
      end
    end
    // doubled vector makes the wrap skip indices >= N
    gnt = N'(({rgnt, rgnt} << base) >> N);
    idx = base + off;
    if (idx >= N) idx = idx - N;
    gnt_idx = SEL_W'(idx);
  end

endmodule

// File: rtl/mux_n_reg.sv
// Registered N:1 word mux with valid/ready per channel,
// explicit-select or round-robin grant, one-entry output register.
module mux_n_reg
  import mux_n_reg_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N     = 8,
  parameter int SEL_W = 3
) (
  input logic          clk,
  input logic          rst_n,
  mux_n_reg_if.slave   bus
);

  if (SEL_W != clog2(N)) begin : g_bad_sel_w
    $error("SEL_W must equal clog2(N)");
  end

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0] out_ch_q, out_ch_d;
  logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;

  logic             mode_rr;
  logic             load_en;
  logic [N-1:0]     gnt_sel;
  logic [N-1:0]     arb_gnt;
  logic [SEL_W-1:0] arb_idx;
  logic             arb_any;
  logic [N-1:0]     gnt;
  logic [SEL_W-1:0] gnt_idx;
  logic             gnt_any;
  logic             xfer;
  logic [WIDTH-1:0] word;

  rr_arbiter #(
    .N     (N),
    .SEL_W (SEL_W)
  ) u_arb (
    .req     (bus.in_valid),
    .ptr     (rr_ptr_q),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx),
    .any     (arb_any)
  );

  assign mode_rr = (bus.mode == MODE_RR);
  assign load_en = !out_valid_q || bus.out_ready;

  // out-of-range sel never matches, so it grants nothing
  always_comb begin
    gnt_sel = '0;
    for (int i = 0; i < N; i++)
      gnt_sel[i] = (int'(bus.sel) == i) && bus.in_valid[i];
  end

  always_comb begin
    gnt     = mode_rr ? arb_gnt : gnt_sel;
    gnt_idx = mode_rr ? arb_idx : bus.sel;
    gnt_any = mode_rr ? arb_any : |gnt_sel;
  end

  assign bus.in_ready =
    (rst_n && load_en && gnt_any) ? gnt : '0;
  assign xfer = |(bus.in_ready & bus.in_valid);

  always_comb begin
    word = '0;
    for (int i = 0; i < N; i++)
      word = word |
        (bus.in_data[i*WIDTH +: WIDTH] & {WIDTH{gnt[i]}});
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    rr_ptr_d    = rr_ptr_q;
    if (load_en) begin
      if (xfer) begin
        out_valid_d = 1'b1;
        out_data_d  = word;
        out_ch_d    = gnt_idx;
        if (mode_rr)
          rr_ptr_d = (int'(gnt_idx) == N - 1) ? '0 :
                     gnt_idx + SEL_W'(1);
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      rr_ptr_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_ch    = out_ch_q;

endmodule

// File: doc/mux_n_reg.md
Name: mux_n_reg

Overview:
- Parametrised, registered N:1 word multiplexer with per-channel valid/ready handshakes.
- Next generation of the fixed 32-bit 8:1 datapath mux: generalised in width and channel count.
- Adds a one-entry output register, backpressure, and a selectable round-robin arbitration mode.
- Sits between multiple producers (register-file read ports, ALU/shift/memory results) and a single consumer stage.

Parameters:
- WIDTH, 32, data word width in bits.
- N, 8, number of input channels (2..16; need not be a power of 2).
- SEL_W, 3, select/channel-index width; must equal ceil(log2(N)).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_data  input  N*WIDTH  flattened channel words; channel i occupies bits [i*WIDTH+WIDTH-1 : i*WIDTH].
- in_valid  input  N  per-channel valid.
- in_ready  output  N  per-channel ready; combinational.
- mode  input  1  0 = explicit select (MODE_SEL), 1 = round-robin (MODE_RR).
- sel  input  SEL_W  channel index, used only in MODE_SEL.
- out_data  output  WIDTH  registered selected word.
- out_ch  output  SEL_W  registered index of the channel that supplied out_data.
- out_valid  output  1  output register holds a word.
- out_ready  input  1  consumer accepts the word.

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, out_data=0, out_ch=0, rr_ptr=0. While rst_n is low, in_ready is all zeros.
- Load enable: load_en = !out_valid || out_ready.
- Grant (one-hot gnt, N bits, combinational):
  - MODE_SEL: gnt[sel]=in_valid[sel]. If sel>=N, gnt=0 and the request is ignored with no error flag.
  - MODE_RR: gnt selects the first i with in_valid[i]=1, scanning rr_ptr, rr_ptr+1, ..., wrapping at N-1 to 0. If no channel is valid, gnt=0.
- Handshake:
  - in_ready[i] = load_en && gnt[i]. At most one bit is set.
  - A transfer occurs on channel i when in_valid[i] && in_ready[i].
  - in_ready must not depend on in_data.
- On a transfer: out_data <= word of channel g; out_ch <= g; out_valid <= 1.
- When load_en=1 and there is no transfer: out_valid <= 0 if it was being consumed; out_data and out_ch hold their values.
- While out_valid=1 and out_ready=0: out_data, out_ch and out_valid are stable, and all in_ready are 0.
- Latency is 1 cycle from transfer to out_valid.
- Throughput is 1 word/cycle with continuous out_ready=1. Consume and load in the same cycle is allowed; out_valid stays 1 and takes the new word.
- rr_ptr:
  - Updates only on a MODE_RR transfer: rr_ptr <= (g==N-1) ? 0 : g+1.
  - MODE_SEL transfers leave rr_ptr unchanged.
- Mode or sel change: takes effect combinationally on the next grant decision. No pipeline flush; a word already held in the output register is unaffected.
- Reset mid-operation: the held word is discarded immediately; no partial state survives.
- Non-power-of-2 N: the round-robin wrap must skip indices >= N.

Decomposition:
- Shared include mux_defs.vh: MODE_SEL=1'b0, MODE_RR=1'b1, and a CLOG2 function/macro for SEL_W checking.
- One sub-module, rr_arbiter (parameter N).
  - Inputs: req[N], ptr[SEL_W]. Outputs: gnt[N] one-hot, gnt_idx[SEL_W], any.
  - Purely combinational rotate/priority/rotate-back.
- rr_ptr register and the output register live in mux_n_reg.

Test Plan:
1. Reset/idle: rst_n=0 with all in_valid=1 -> out_valid=0, out_data=0, out_ch=0, in_ready=0. Release reset with MODE_SEL, sel=3, in_valid=0 -> out_valid stays 0.
2. Explicit select latency: N=8, WIDTH=32, mode=0, sel=5, channel 5=32'hDEAD_BEEF, in_valid[5]=1, out_ready=1 -> in_ready=8'b0010_0000 that cycle; next cycle out_data=32'hDEAD_BEEF, out_ch=5, out_valid=1.
3. Backpressure: continue test 2 with out_ready=0 for 3 cycles while channel 5 changes to 32'h1234_5678 -> out_data holds DEADBEEF and in_ready=0 throughout. out_ready=1 -> 1234_5678 appears one cycle later, no word lost or duplicated.
4. Round-robin fairness: mode=1, in_valid=8'b1000_1001, out_ready=1 continuously -> out_ch sequence 0,3,7,0,3,7; rr_ptr wraps 7->0.
5. Non-power-of-2: N=5, SEL_W=3, mode=0, sel=6, all in_valid=1 -> in_ready=0 and out_valid never rises. mode=1 with in_valid=5'b10001 -> out_ch 0,4,0,4.
6. Async reset mid-stream: out_valid=1 holding out_ch=3, assert rst_n low between clock edges -> out_valid=0 before the next edge, and rr_ptr=0 after release (first RR grant goes to the lowest valid channel).
